// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_LAT_DEFAULT = 2;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;

    // Bit positions inside the one-hot grant vector
    localparam int unsigned GNT_IF = 0;
    localparam int unsigned GNT_D  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to
// whichever port did not own the previous access.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  owner_e     last_owner,
    output logic [1:0] gnt_c
);

    always_comb begin
        gnt_c         = '0;
        gnt_c[GNT_D]  = d_req  & (~if_req | (last_owner == OWN_IF));
        gnt_c[GNT_IF] = if_req & (~d_req  | (last_owner == OWN_D));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one fixed-latency memory,
// one outstanding access at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    owner_e           last_owner_q, owner_d;
    logic             is_wr_q, wr_d;
    logic [1:0]       pick_c;
    logic             resp_load_c;
    mem_req_t         win_c;

    mem_arb_rr u_rr (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_owner (last_owner_q),
        .gnt_c      (pick_c)
    );

    // State, latency counter and owner bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_owner_q <= OWN_IF;
            is_wr_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= owner_d;
            is_wr_q      <= wr_d;
        end
    end

    // Response capture: memory data is sampled at the end of the last WAIT cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= resp_load_c && (last_owner_q == OWN_IF);
            d_rvalid  <= resp_load_c && (last_owner_q == OWN_D);
            if (resp_load_c && (last_owner_q == OWN_IF)) begin
                if_rdata <= mem_rdata;
            end
            if (resp_load_c && (last_owner_q == OWN_D)) begin
                d_rdata <= is_wr_q ? '0 : mem_rdata;
            end
        end
    end

    // Next state plus the same-cycle grant and memory strobe
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = last_owner_q;
        wr_d        = is_wr_q;
        resp_load_c = 1'b0;
        win_c       = '0;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        mem_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // reset_n gating keeps grants quiet while reset is held
                if (reset_n && (pick_c != 2'b00)) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                    mem_en  = 1'b1;
                    if (pick_c[GNT_D]) begin
                        d_gnt   = 1'b1;
                        owner_d = OWN_D;
                        wr_d    = d_we;
                        win_c   = '{we: d_we, addr: d_addr, wdata: d_wdata};
                    end else begin
                        if_gnt  = 1'b1;
                        owner_d = OWN_IF;
                        wr_d    = 1'b0;
                        win_c   = '{we: 1'b0, addr: if_addr, wdata: '0};
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = ST_RESP;
                    resp_load_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_we    = win_c.we;
        mem_addr  = win_c.addr;
        mem_wdata = win_c.wdata;
    end

endmodule
